// File: rtl/pc_sequencer.sv
// PC sequencer for the single-cycle core: owns the PC and feeds op/funct to the decoder.
// It selects the next PC from jump/branch/jr and adds a boot cycle, a halt state and a retire counter.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [31:0] instr,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        valid,
    output logic        halted,
    output logic        err,
    output logic [31:0] inst_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] br_off;
    logic [31:0] next_pc;

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};

    assign valid    = (state_q == RUN) && en;
    assign op       = valid ? instr[31:26] : 6'b000000;
    assign funct    = valid ? instr[5:0]   : 6'b000000;
    assign halted   = (state_q == HALT);
    assign err      = err_q;
    assign inst_cnt = cnt_q;

    // Redirect priority: jr over jump over taken branch over fall-through.
    always_comb begin
        if (jr)
            next_pc = jr_addr;
        else if (jump)
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (branch && zero)
            next_pc = pc_plus4 + br_off;
        else
            next_pc = pc_plus4;
    end

    always_comb begin
        // NOTE: every output of this block is given a hold default first, so no path can infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (en) begin
                    if (instr[31:26] == HALT_OP) begin
                        state_d = HALT;
                    end else begin
                        cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
                        // A misaligned jr still retires but parks the core with err set.
                        if (jr && (jr_addr[1:0] != 2'b00)) begin
                            state_d = HALT;
                            err_d   = 1'b1;
                        end else begin
                            pc_d = next_pc;
                        end
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer; a second instance with RESET_PC at the top
// of the address space covers the PC wrap.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [31:0] instr;
    logic        jump, branch, zero, jr;
    logic [31:0] jr_addr;

    logic [31:0] imem_addr, pc, pc_plus4, inst_cnt;
    logic [5:0]  op, funct;
    logic        valid, halted, err;

    logic [31:0] w_imem_addr, w_pc, w_pc_plus4, w_inst_cnt;
    logic [5:0]  w_op, w_funct;
    logic        w_valid, w_halted, w_err;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset_n(reset_n), .en(en), .instr(instr),
        .jump(jump), .branch(branch), .zero(zero), .jr(jr), .jr_addr(jr_addr),
        .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4), .op(op), .funct(funct),
        .valid(valid), .halted(halted), .err(err), .inst_cnt(inst_cnt)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset_n(reset_n), .en(en), .instr(instr),
        .jump(jump), .branch(branch), .zero(zero), .jr(jr), .jr_addr(jr_addr),
        .imem_addr(w_imem_addr), .pc(w_pc), .pc_plus4(w_pc_plus4), .op(w_op), .funct(w_funct),
        .valid(w_valid), .halted(w_halted), .err(w_err), .inst_cnt(w_inst_cnt)
    );

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [31:0] instr;
        logic        jump, branch, zero, jr;
        logic [31:0] jr_addr;
        logic [31:0] e_pc;
        logic        e_valid, e_halted, e_err;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] NOP  = 32'h0000_0020;
    localparam logic [31:0] BEQ  = 32'h1000_FFFE;
    localparam logic [31:0] JMP  = 32'h0800_0100;
    localparam logic [31:0] JRI  = 32'h0000_0008;
    localparam logic [31:0] HLT  = 32'hFC00_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic [31:0] ins,
                       input logic j, input logic b, input logic z, input logic jrs,
                       input logic [31:0] jra, input logic [31:0] xpc, input logic xv,
                       input logic xh, input logic xe, input logic [31:0] xcnt);
        vec_t v;
        v.rst_n = r;  v.en = e;  v.instr = ins;
        v.jump = j;   v.branch = b; v.zero = z; v.jr = jrs; v.jr_addr = jra;
        v.e_pc = xpc; v.e_valid = xv; v.e_halted = xh; v.e_err = xe; v.e_cnt = xcnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        reset_n = v.rst_n; en = v.en; instr = v.instr;
        jump = v.jump; branch = v.branch; zero = v.zero; jr = v.jr; jr_addr = v.jr_addr;
    endtask

    initial begin
        // Each row: inputs for one cycle and the outputs expected before that cycle's edge.
        //   rst en instr  j  b  z  jr jr_addr        pc            v  h  e  cnt
        add(1, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0000, 0, 0, 0, 0);   // BOOT
        add(1, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0000, 1, 0, 0, 0);
        add(1, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0004, 1, 0, 0, 1);
        add(1, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0008, 1, 0, 0, 2);
        add(1, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_000C, 1, 0, 0, 3);
        add(1, 1, BEQ,  0, 1, 1, 0, 32'h0,        32'h0000_0010, 1, 0, 0, 4);   // taken -> 0x0C
        add(1, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_000C, 1, 0, 0, 5);
        add(1, 1, BEQ,  0, 1, 0, 0, 32'h0,        32'h0000_0010, 1, 0, 0, 6);   // not taken
        add(1, 1, JRI,  0, 0, 0, 1, 32'h2000_0040, 32'h0000_0014, 1, 0, 0, 7);
        add(1, 1, JMP,  1, 1, 1, 0, 32'h0,        32'h2000_0040, 1, 0, 0, 8);   // jump beats branch
        add(1, 1, JMP,  1, 1, 1, 1, 32'h0000_0080, 32'h2000_0400, 1, 0, 0, 9);  // jr beats both
        add(1, 0, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0080, 0, 0, 0, 10);  // en=0 x3
        add(1, 0, BEQ,  0, 1, 1, 0, 32'h0,        32'h0000_0080, 0, 0, 0, 10);
        add(1, 0, JMP,  1, 0, 0, 0, 32'h0,        32'h0000_0080, 0, 0, 0, 10);
        add(1, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0080, 1, 0, 0, 10);
        add(1, 1, JRI,  0, 0, 0, 1, 32'h0000_0082, 32'h0000_0084, 1, 0, 0, 11); // misaligned jr
        add(1, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0084, 0, 1, 1, 12);
        add(1, 0, JRI,  0, 0, 0, 1, 32'h0000_0100, 32'h0000_0084, 0, 1, 1, 12);
        add(0, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0084, 0, 1, 1, 12);  // reset from HALT
        add(1, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0000, 0, 0, 0, 0);   // BOOT
        add(1, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0000, 1, 0, 0, 0);
        add(1, 1, HLT,  0, 0, 0, 0, 32'h0,        32'h0000_0004, 1, 0, 0, 1);   // halt opcode
        add(1, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0004, 0, 1, 0, 1);
        add(1, 0, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0004, 0, 1, 0, 1);
        add(1, 1, JMP,  1, 0, 0, 0, 32'h0,        32'h0000_0004, 0, 1, 0, 1);
        add(0, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0004, 0, 1, 0, 1);
        add(1, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0000, 0, 0, 0, 0);   // BOOT
        add(1, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0000, 1, 0, 0, 0);
        add(0, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0004, 1, 0, 0, 1);   // mid-RUN reset
        add(1, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0000, 0, 0, 0, 0);   // BOOT
        add(1, 1, NOP,  0, 0, 0, 0, 32'h0,        32'h0000_0000, 1, 0, 0, 0);

        // Reset held for two edges with a non-NOP instruction present.
        reset_n = 1'b0; en = 1'b1; instr = JMP;
        jump = 1'b0; branch = 1'b0; zero = 1'b0; jr = 1'b0; jr_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset pc",       pc,        32'h0);
        check("reset cnt",      inst_cnt,  32'h0);
        check("reset valid",    {31'b0, valid},  32'h0);
        check("reset halted",   {31'b0, halted}, 32'h0);
        check("reset err",      {31'b0, err},    32'h0);
        check("reset op",       {26'b0, op},     32'h0);
        check("reset wrap pc",  w_pc,      32'hFFFF_FFFC);

        for (int i = 0; i < vecs.size(); i++) begin
            logic [31:0] xop, xfn;
            drive(vecs[i]);
            xop = vecs[i].e_valid ? {26'b0, vecs[i].instr[31:26]} : 32'h0;
            xfn = vecs[i].e_valid ? {26'b0, vecs[i].instr[5:0]}   : 32'h0;
            @(negedge clk);
            check($sformatf("v%0d pc", i),       pc,        vecs[i].e_pc);
            check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_pc);
            check($sformatf("v%0d pc_plus4", i), pc_plus4,  vecs[i].e_pc + 32'd4);
            check($sformatf("v%0d valid", i),    {31'b0, valid},  {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d halted", i),   {31'b0, halted}, {31'b0, vecs[i].e_halted});
            check($sformatf("v%0d err", i),      {31'b0, err},    {31'b0, vecs[i].e_err});
            check($sformatf("v%0d inst_cnt", i), inst_cnt,  vecs[i].e_cnt);
            check($sformatf("v%0d op", i),       {26'b0, op},     xop);
            check($sformatf("v%0d funct", i),    {26'b0, funct},  xfn);
            // Wrap instance shares the first three cycles: BOOT, NOP at 0xFFFFFFFC, then 0x0.
            if (i == 0) begin
                check("wrap boot pc",    w_pc, 32'hFFFF_FFFC);
                check("wrap boot valid", {31'b0, w_valid}, 32'h0);
            end else if (i == 1) begin
                check("wrap pc",        w_pc,       32'hFFFF_FFFC);
                check("wrap pc_plus4",  w_pc_plus4, 32'h0000_0000);
                check("wrap valid",     {31'b0, w_valid}, 32'h1);
            end else if (i == 2) begin
                check("wrap stepped pc", w_pc,       32'h0000_0000);
                check("wrap cnt",        w_inst_cnt, 32'h1);
                check("wrap err",        {31'b0, w_err},    32'h0);
                check("wrap halted",     {31'b0, w_halted}, 32'h0);
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
